uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (2-flop synchronised rx, mid-bit sampling) feeding a show-ahead word FIFO; word lands 1 cycle after stop sample.
// No backpressure on the line: a push into a full FIFO is dropped and sets sticky rx_ovr. Define UART_RX_FIFO_PARITY_EN for a parity bit.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    input  logic [15:0]                 baud_div,
    input  logic                        parity_odd,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_ferr,
    output logic                        rx_perr,
    input  logic                        rx_pop,
    output logic                        rx_empty,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        rx_ovr,
    input  logic                        ovr_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] LVL_ONE = (AW + 1)'(1);

`ifdef UART_RX_FIFO_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    typedef struct packed {
        logic                 perr;
        logic                 ferr;
        logic [DATA_BITS-1:0] data;
    } entry_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    typedef struct packed {
        logic                 ferr;
        logic [DATA_BITS-1:0] data;
    } entry_t;
`endif

    state_t               state_q, state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]           warm_q;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push_q, push_d;
    logic                 wferr_q, wferr_d;
    logic                 fall, tick;
`ifdef UART_RX_FIFO_PARITY_EN
    logic                 par_q, par_d;
    logic                 wperr_q, wperr_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // warm_q keeps a line that was already low at reset release from looking like a fresh start edge
    assign fall = warm_q[2] & rx_prev_q & ~rx_s2_q;
    assign tick = (cnt_q == 16'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        push_d  = 1'b0;
        wferr_d = wferr_q;
`ifdef UART_RX_FIFO_PARITY_EN
        par_d   = par_q;
        wperr_d = wperr_q;
`endif
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = baud_div >> 1;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rx_s2_q) begin
                    state_d = DATA;
                    cnt_d   = baud_div;
                    bit_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shreg_d = {rx_s2_q, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = baud_div;
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_FIFO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_FIFO_PARITY_EN
            PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    par_d   = rx_s2_q;
                    cnt_d   = baud_div;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    push_d  = 1'b1;
                    wferr_d = ~rx_s2_q;
`ifdef UART_RX_FIFO_PARITY_EN
                    wperr_d = ^shreg_q ^ par_q ^ parity_odd;
`endif
                    state_d = rx_s2_q ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            warm_q    <= 3'b000;
            cnt_q     <= 16'd0;
            bit_q     <= 4'd0;
            shreg_q   <= '0;
            push_q    <= 1'b0;
            wferr_q   <= 1'b0;
`ifdef UART_RX_FIFO_PARITY_EN
            par_q     <= 1'b0;
            wperr_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            warm_q    <= {warm_q[1:0], 1'b1};
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            push_q    <= push_d;
            wferr_q   <= wferr_d;
`ifdef UART_RX_FIFO_PARITY_EN
            par_q     <= par_d;
            wperr_q   <= wperr_d;
`endif
        end
    end

    entry_t        mem_q [FIFO_DEPTH];
    entry_t        wr_entry, head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          ovr_q, full, do_pop, do_push;

    assign full    = (level_q == LVL_FULL);
    assign do_pop  = rx_pop && (level_q != '0);
    assign do_push = push_q && (!full || do_pop);

`ifdef UART_RX_FIFO_PARITY_EN
    assign wr_entry = '{perr: wperr_q, ferr: wferr_q, data: shreg_q};
`else
    assign wr_entry = '{ferr: wferr_q, data: shreg_q};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - LVL_ONE;
            end
            // an overrun in the same cycle as ovr_clr keeps the flag set
            if (push_q && full && !do_pop) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head     = mem_q[rd_ptr_q];
    assign rx_data  = head.data;
    assign rx_ferr  = head.ferr;
`ifdef UART_RX_FIFO_PARITY_EN
    assign rx_perr  = head.perr;
`else
    assign rx_perr  = 1'b0;
`endif
    assign rx_empty = (level_q == '0);
    assign rx_level = level_q;
    assign rx_ovr   = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (DATA_BITS=8, FIFO_DEPTH=4): directed vectors, corner sequences and random frames vs a word-queue model.
module tb_uart_rx_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   rx = 1'b1;
    logic                   parity_odd = 1'b0;
    logic                   rx_pop = 1'b0;
    logic                   ovr_clr = 1'b0;
    logic [15:0]            baud_div = 16'd9;
    logic [DB-1:0]          rx_data;
    logic                   rx_ferr, rx_perr, rx_empty, rx_ovr;
    logic [$clog2(DEPTH):0] rx_level;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic          perr;
        logic          ferr;
        logic [DB-1:0] data;
    } word_t;
    word_t model_q[$];
    logic  model_ovr = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic [2:0] exp_level;
    } vec_t;
    vec_t vecs[6];

    uart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .baud_div   (baud_div),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_ferr    (rx_ferr),
        .rx_perr    (rx_perr),
        .rx_pop     (rx_pop),
        .rx_empty   (rx_empty),
        .rx_level   (rx_level),
        .rx_ovr     (rx_ovr),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ^d ^ parity_odd;
    endfunction

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (int'(baud_div) + 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic model_push(input logic [7:0] d, input logic par, input logic stop);
        word_t w;
        w.data = d;
        w.ferr = ~stop;
        w.perr = PAR_EN ? (^d ^ par ^ parity_odd) : 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else model_ovr = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input logic par, input logic stop);
        send_frame(d, par, stop);
        model_push(d, par, stop);
        repeat (int'(baud_div) + 6) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, ".level"}, 32'(rx_level), model_q.size());
        check({tag, ".empty"}, 32'(rx_empty), (model_q.size() == 0) ? 1 : 0);
        check({tag, ".ovr"}, 32'(rx_ovr), 32'(model_ovr));
        if (model_q.size() != 0) begin
            check({tag, ".data"}, 32'(rx_data), 32'(model_q[0].data));
            check({tag, ".ferr"}, 32'(rx_ferr), 32'(model_q[0].ferr));
            check({tag, ".perr"}, 32'(rx_perr), 32'(model_q[0].perr));
        end
    endtask

    task automatic pop();
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        model_ovr = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        model_ovr = 1'b0;
    endtask

    initial begin
        int         n;
        logic [7:0] d;
        logic       stop;
        logic       par;

        vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd1};
        vecs[1] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 3'd1};
        vecs[2] = '{8'h81, 1'b1, 8'h81, 1'b0, 3'd1};
        vecs[3] = '{8'h5A, 1'b0, 8'h5A, 1'b1, 3'd1};
        vecs[4] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 3'd1};
        vecs[5] = '{8'h01, 1'b1, 8'h01, 1'b0, 3'd1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset.empty", 32'(rx_empty), 1);
        check("reset.level", 32'(rx_level), 0);
        check("reset.ovr", 32'(rx_ovr), 0);
        check("reset.perr", 32'(rx_perr), PAR_EN ? 32'(rx_perr) : 0);

        // 0xA5 must be visible within 100 clk of its start edge
        n = 0;
        fork
            send_frame(8'hA5, good_par(8'hA5), 1'b1);
            begin
                while (rx_empty && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("a5.latency_le_100", 32'(rx_empty), 0);
            end
        join
        model_push(8'hA5, good_par(8'hA5), 1'b1);
        repeat (16) @(negedge clk);
        check("a5.data", 32'(rx_data), 32'h A5);
        check("a5.ferr", 32'(rx_ferr), 0);
        check("a5.level", 32'(rx_level), 1);
        compare("a5");
        pop();
        compare("a5_pop");

        // 3-clk low glitch is rejected
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch.empty", 32'(rx_empty), 1);
        check("glitch.level", 32'(rx_level), 0);

        for (int i = 0; i < 6; i++) begin
            frame(vecs[i].data, good_par(vecs[i].data), vecs[i].stop);
            check($sformatf("vec%0d.data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d.ferr", i), 32'(rx_ferr), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d.level", i), 32'(rx_level), 32'(vecs[i].exp_level));
            pop();
            compare($sformatf("vec%0d_pop", i));
        end

`ifdef UART_RX_FIFO_PARITY_EN
        parity_odd = 1'b0;
        frame(8'h03, 1'b1, 1'b1);
        check("par.perr", 32'(rx_perr), 1);
        check("par.data", 32'(rx_data), 32'h03);
        pop();
`endif

        // 30-bit break gives exactly one 0x00 word with ferr
        rx = 1'b0;
        repeat (300) @(negedge clk);
        rx = 1'b1;
        model_push(8'h00, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("break.level", 32'(rx_level), 1);
        check("break.data", 32'(rx_data), 0);
        check("break.ferr", 32'(rx_ferr), 1);
        frame(8'h5A, good_par(8'h5A), 1'b1);
        compare("after_break");
        pop();
        compare("after_break_pop1");
        check("after_break.data", 32'(rx_data), 32'h5A);
        pop();

        // reset during data bit 4 discards the frame and the buffered word
        frame(8'h77, good_par(8'h77), 1'b1);
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        repeat (5) @(negedge clk);
        rx = 1'b1;
        pulse_reset();
        repeat (150) @(negedge clk);
        check("rst_mid.empty", 32'(rx_empty), 1);
        check("rst_mid.level", 32'(rx_level), 0);
        frame(8'h3C, good_par(8'h3C), 1'b1);
        check("rst_mid.next", 32'(rx_data), 32'h3C);
        compare("rst_mid_next");
        pop();

        // line already low when reset releases: no frame
        rx = 1'b0;
        pulse_reset();
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        compare("low_at_release");

        // five frames into a 4-deep buffer
        for (int i = 1; i <= 5; i++) frame(8'(i * 8'h11), good_par(8'(i * 8'h11)), 1'b1);
        check("ovr.level", 32'(rx_level), 4);
        check("ovr.flag", 32'(rx_ovr), 1);
        check("ovr.head", 32'(rx_data), 32'h11);
        compare("ovr");
        clear_ovr();
        check("ovr_clr.flag", 32'(rx_ovr), 0);
        for (int i = 0; i < 4; i++) begin
            compare($sformatf("drain%0d", i));
            pop();
        end
        pop();
        compare("pop_empty");

        for (int it = 0; it < 40; it++) begin
            baud_div   = 16'($urandom_range(3, 12));
            parity_odd = 1'($urandom_range(0, 1));
            d          = 8'($urandom);
            stop       = ($urandom_range(0, 7) != 0);
            par        = good_par(d) ^ ($urandom_range(0, 5) == 0);
            frame(d, par, stop);
            compare($sformatf("rnd%0d", it));
            if ($urandom_range(0, 1) != 0) begin
                pop();
                compare($sformatf("rnd%0d_pop", it));
            end
            if ($urandom_range(0, 4) == 0) clear_ovr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
